// File: rtl/lsu.sv
// Load/store unit between the MEM stage and a multi-cycle word-wide data memory.
// Issues word-aligned read/write strobes, stalls the core until the access
// completes, extends sub-word load data, and can merge sub-word stores into the
// read word before writing it back.
// Optional feature macro: LSU_RMW_EN -- when defined, sb/sh are performed as
// read-modify-write; when undefined, sb/sh are rejected as illegal accesses.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvd,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        illegal;
  logic        acc_err;
  logic        accept;
  logic [31:0] shifted;
  logic [31:0] ext;
`ifdef LSU_RMW_EN
  logic [31:0] merged;
`endif

  // Classify the incoming request: misaligned or unsupported width codes.
  always_comb begin
    illegal = 1'b0;
    if (i_we) begin
      case (i_funct3)
`ifdef LSU_RMW_EN
        3'b000:  illegal = 1'b0;
        3'b001:  illegal = i_addr[0];
`endif
        3'b010:  illegal = |i_addr[1:0];
        default: illegal = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        3'b000, 3'b100: illegal = 1'b0;
        3'b001, 3'b101: illegal = i_addr[0];
        3'b010:         illegal = |i_addr[1:0];
        default:        illegal = 1'b1;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state decode; acc_err flags an illegal request rejected from IDLE.
  always_comb begin
    nxt     = state;
    acc_err = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req) begin
          if (illegal) begin
            nxt     = DONE;
            acc_err = 1'b1;
          end else begin
            accept = 1'b1;
            if (i_we && (i_funct3 == 3'b010)) nxt = WR;
            else                              nxt = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: nxt = RD_WAIT;
      RD_WAIT: begin
        if (i_mem_rvd) begin
`ifdef LSU_RMW_EN
          nxt = we_q ? WR : DONE;
`else
          nxt = DONE;
`endif
        end
      end
      WR:      nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Pipeline freeze: combinational so the core stalls in the accept cycle.
  always_comb begin
    o_stall = ((state == IDLE) && i_req) || (state == RD_ISSUE) ||
              (state == RD_WAIT) || (state == WR);
  end

  // Align the returned word to the addressed byte and extend per width code.
  always_comb begin
    shifted = i_mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

`ifdef LSU_RMW_EN
  // Insert the held store byte/halfword into the word read from memory.
  always_comb begin
    merged = i_mem_rdata;
    if (f3_q[0]) begin
      if (off_q[1]) merged[31:16] = o_mem_wdata[15:0];
      else          merged[15:0]  = o_mem_wdata[15:0];
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = o_mem_wdata[7:0];
        2'd1:    merged[15:8]  = o_mem_wdata[7:0];
        2'd2:    merged[23:16] = o_mem_wdata[7:0];
        default: merged[31:24] = o_mem_wdata[7:0];
      endcase
    end
  end
`endif

  // Registered outputs and request latches; strobes are decoded from the
  // upcoming state so each is high exactly while the FSM sits in that state.
  // o_mem_wdata doubles as the holding register for sub-word store data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_mem_ren   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
    end else begin
      o_done    <= (nxt == DONE);
      o_err     <= acc_err;
      o_mem_ren <= (nxt == RD_ISSUE);
      o_mem_wen <= (nxt == WR);
      o_rdata   <= (state == RD_WAIT && i_mem_rvd && !we_q) ? ext : '0;
      if (accept) begin
        o_mem_addr <= {i_addr[31:2], 2'b00};
        f3_q       <= i_funct3;
        off_q      <= i_addr[1:0];
        we_q       <= i_we;
        if (i_we) o_mem_wdata <= i_wdata;
      end
`ifdef LSU_RMW_EN
      if (state == RD_WAIT && i_mem_rvd && we_q) o_mem_wdata <= merged;
`endif
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a DELAY=5 memory model and a done-driven scoreboard.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvd;
  logic [31:0] i_mem_rdata;

  lsu dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done),
    .o_rdata(o_rdata), .o_err(o_err), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rvd(i_mem_rvd),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ren_count = 0;
  int   wen_count = 0;
  int   ren_cyc = 0;
  int   wen_cyc = 0;
  int   rvd_cyc = 0;
  int   stray_rdata = 0;
  int   bad_addr = 0;

  // Memory model: 256 words, rvd four cycles after the read strobe.
  logic [31:0] mem [0:255];
  int          pend;
  logic [7:0]  pend_idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= 0;
      i_mem_rvd   <= 1'b0;
      i_mem_rdata <= '0;
    end else begin
      i_mem_rvd <= 1'b0;
      if (pend == 1) begin
        i_mem_rvd   <= 1'b1;
        i_mem_rdata <= mem[pend_idx];
        pend        <= 0;
      end else if (pend > 1) begin
        pend <= pend - 1;
      end
      if (o_mem_ren) begin
        pend     <= 3;
        pend_idx <= o_mem_addr[9:2];
      end
      if (o_mem_wen) mem[o_mem_addr[9:2]] <= o_mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: strobe bookkeeping and scoreboard pop on each completion.
  always @(negedge clk) begin
    if (o_mem_ren) begin ren_count++; ren_cyc = cyc; end
    if (o_mem_wen) begin wen_count++; wen_cyc = cyc; end
    if (i_mem_rvd) rvd_cyc = cyc;
    if ((o_mem_ren || o_mem_wen) && o_mem_addr[1:0] != 2'b00) bad_addr++;
    if (!o_done && o_rdata != 32'd0) stray_rdata++;
    if (o_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_rdata"}, o_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, o_err}, {31'd0, e.err});
      end
    end
  end

  // Issue one access at a negedge; skip=1 when the DUT is in DONE of a prior one.
  task automatic do_acc(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_ren, input int exp_wen,
                        input int skip, input logic hold, output int c0);
    int   r0, w0, n;
    logic stall_bad;
    exp_t e;
    r0 = ren_count; w0 = wen_count;
    e.name = nm; e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    c0 = cyc + skip;
    stall_bad = 1'b0;
    #1;
    if (skip == 0 && !o_stall) stall_bad = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (o_done || n > 60) break;
      if (cyc >= c0 && !o_stall) stall_bad = 1'b1;
    end
    chk({nm, "_timeout"}, {31'd0, (n > 60)}, 32'd0);
    chk({nm, "_latency"}, cyc - c0, exp_lat);
    chk({nm, "_stall_busy"}, {31'd0, stall_bad}, 32'd0);
    chk({nm, "_stall_done"}, {31'd0, o_stall}, 32'd0);
    chk({nm, "_ren_cnt"}, ren_count - r0, exp_ren);
    chk({nm, "_wen_cnt"}, wen_count - w0, exp_wen);
    if (!hold) i_req = 1'b0;
  endtask

  logic [31:0] exp_sb_err;
  logic [31:0] exp_word;
  int          c0;
  int          r1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_done, o_err, o_mem_ren, o_mem_wen, o_stall, 27'd0} |
        o_rdata | o_mem_addr | o_mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_acc("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 2, 0, 1, 0, 1'b0, c0);
    chk("sw_wen_cycle", wen_cyc - c0, 32'd1);
    @(negedge clk);
    do_acc("lw_100", 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 6, 1, 0, 0, 1'b0, c0);
    chk("lw_ren_cycle", ren_cyc - c0, 32'd1);
    chk("lw_rvd_cycle", rvd_cyc - c0, 32'd5);
    @(negedge clk);
    do_acc("lb_103",  1'b0, 3'b000, 32'h103, 32'd0, 32'hFFFFFFDE, 1'b0, 6, 1, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("lbu_103", 1'b0, 3'b100, 32'h103, 32'd0, 32'h000000DE, 1'b0, 6, 1, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("lh_102",  1'b0, 3'b001, 32'h102, 32'd0, 32'hFFFFDEAD, 1'b0, 6, 1, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("lhu_100", 1'b0, 3'b101, 32'h100, 32'd0, 32'h0000BEEF, 1'b0, 6, 1, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("sw_104", 1'b1, 3'b010, 32'h104, 32'h12345678, 32'd0, 1'b0, 2, 0, 1, 0, 1'b0, c0);
    @(negedge clk);

`ifdef LSU_RMW_EN
    do_acc("sb_101", 1'b1, 3'b000, 32'h101, 32'h00000055, 32'd0, 1'b0, 7, 1, 1, 0, 1'b0, c0);
    chk("sb_wen_cycle", wen_cyc - c0, 32'd6);
    exp_word = 32'hDEAD55EF;
`else
    do_acc("sb_101", 1'b1, 3'b000, 32'h101, 32'h00000055, 32'd0, 1'b1, 1, 0, 0, 0, 1'b0, c0);
    exp_word = 32'hDEADBEEF;
`endif
    @(negedge clk);
    do_acc("lw_after_sb", 1'b0, 3'b010, 32'h100, 32'd0, exp_word, 1'b0, 6, 1, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("lw_102_mis", 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("sh_101_mis", 1'b1, 3'b001, 32'h101, 32'h0000AAAA, 32'd0, 1'b1, 1, 0, 0, 0, 1'b0, c0);
    @(negedge clk);
    do_acc("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0, 1'b0, c0);
    @(negedge clk);

    // Reset while a lb sits in RD_WAIT.
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b000; i_addr = 32'h100;
    repeat (3) @(negedge clk);
    rst = 1'b1; i_req = 1'b0;
    #1;
    chk("midrst_outputs", {o_done, o_err, o_mem_ren, o_mem_wen, o_stall, 27'd0} |
        o_rdata | o_mem_addr | o_mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_acc("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'd0, exp_word, 1'b0, 6, 1, 0, 0, 1'b0, c0);

    // Back-to-back loads with i_req held through the first DONE.
    @(negedge clk);
    do_acc("b2b_lw_100", 1'b0, 3'b010, 32'h100, 32'd0, exp_word, 1'b0, 6, 1, 0, 0, 1'b1, c0);
    r1 = rvd_cyc;
    do_acc("b2b_lw_104", 1'b0, 3'b010, 32'h104, 32'd0, 32'h12345678, 1'b0, 6, 1, 0, 1, 1'b0, c0);
    chk("b2b_ren_gap_ge2", {31'd0, (ren_cyc - r1) >= 2}, 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    chk("rdata_zero_outside_done", stray_rdata, 32'd0);
    chk("mem_addr_aligned", bad_addr, 32'd0);
    exp_sb_err = 32'd0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
